// File: rtl/s_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// s_mem_arbiter_if
// Requester-side bus of the S memory arbiter. It bundles the request,
// lock and write signals of all three requesters (init=0, ksa=1, prga=2)
// with the ack/rdvalid strobes and the shared read data.
//   master : the requesters (sequencer side); drives req/lock/wren/addr/wrdata
//   slave  : the arbiter; drives ack/rdvalid/rddata
// ---------------------------------------------------------------------------
interface s_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [2:0]    req;
  logic [2:0]    lock;
  logic [2:0]    wren;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wrdata0;
  logic [DW-1:0] wrdata1;
  logic [DW-1:0] wrdata2;
  logic [2:0]    ack;
  logic [2:0]    rdvalid;
  logic [DW-1:0] rddata;

  modport master (
    output req, lock, wren, addr0, addr1, addr2, wrdata0, wrdata1, wrdata2,
    input  ack, rdvalid, rddata
  );

  modport slave (
    input  req, lock, wren, addr0, addr1, addr2, wrdata0, wrdata1, wrdata2,
    output ack, rdvalid, rddata
  );
endinterface

// File: rtl/s_mem_arbiter.sv
// ---------------------------------------------------------------------------
// s_mem_arbiter
// Shares the single-port 256x8 S memory between init (0), ksa (1) and
// prga (2). Round-robin arbitration, at most one access per cycle, with a
// lock so ksa/prga can run an uninterrupted read-read-write-write swap.
// Ports:
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   bus      : requester bus (slave modport of s_mem_arbiter_if)
//   mem_addr : address to s_mem
//   mem_data : write data to s_mem
//   mem_wren : write enable to s_mem
//   mem_q    : read data from s_mem (1-cycle latency)
// ---------------------------------------------------------------------------
module s_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  s_mem_arbiter_if.slave         bus,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_data,
  output logic                   mem_wren,
  input  logic [DW-1:0]          mem_q
);

  logic [1:0] last_grant;
  logic       lock_valid;
  logic [1:0] lock_owner;
  logic [2:0] rd_pending;

  logic [2:0] owner_mask;
  logic [2:0] cand;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic [2:0] grant_onehot;
  logic       sel_wren;
  logic       sel_lock;

  assign owner_mask = 3'b001 << lock_owner;

  // While a lock is held only the owner may compete. The search begins
  // one past the last grant so the previous winner has lowest priority.
  always_comb begin
    cand        = lock_valid ? (bus.req & owner_mask) : bus.req;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    case (last_grant)
      2'd0: begin
        if (cand[1])      begin grant_valid = 1'b1; grant_idx = 2'd1; end
        else if (cand[2]) begin grant_valid = 1'b1; grant_idx = 2'd2; end
        else if (cand[0]) begin grant_valid = 1'b1; grant_idx = 2'd0; end
      end
      2'd1: begin
        if (cand[2])      begin grant_valid = 1'b1; grant_idx = 2'd2; end
        else if (cand[0]) begin grant_valid = 1'b1; grant_idx = 2'd0; end
        else if (cand[1]) begin grant_valid = 1'b1; grant_idx = 2'd1; end
      end
      default: begin
        if (cand[0])      begin grant_valid = 1'b1; grant_idx = 2'd0; end
        else if (cand[1]) begin grant_valid = 1'b1; grant_idx = 2'd1; end
        else if (cand[2]) begin grant_valid = 1'b1; grant_idx = 2'd2; end
      end
    endcase
  end

  // Route the winner's request onto the memory port. Everything is held at
  // zero during reset so no stray write reaches s_mem.
  always_comb begin
    grant_onehot = 3'b000;
    sel_wren     = 1'b0;
    sel_lock     = 1'b0;
    mem_addr     = '0;
    mem_data     = '0;
    mem_wren     = 1'b0;
    if (rst_n && grant_valid) begin
      grant_onehot = 3'b001 << grant_idx;
      case (grant_idx)
        2'd0: begin
          mem_addr = bus.addr0;
          mem_data = bus.wrdata0;
          sel_wren = bus.wren[0];
          sel_lock = bus.lock[0];
        end
        2'd1: begin
          mem_addr = bus.addr1;
          mem_data = bus.wrdata1;
          sel_wren = bus.wren[1];
          sel_lock = bus.lock[1];
        end
        default: begin
          mem_addr = bus.addr2;
          mem_data = bus.wrdata2;
          sel_wren = bus.wren[2];
          sel_lock = bus.lock[2];
        end
      endcase
      mem_wren = sel_wren;
    end
  end

  assign bus.ack     = grant_onehot;
  // Gated by rst_n so a read issued just before reset never returns.
  assign bus.rdvalid = rd_pending & {3{rst_n}};
  assign bus.rddata  = mem_q;

  // Pointer, read-return and lock bookkeeping. A lock ends when the owner
  // drops req or completes an access with lock low; last_grant then points
  // at the owner, making it lowest priority for the next round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 2'd2;
      lock_valid <= 1'b0;
      lock_owner <= 2'd0;
      rd_pending <= 3'b000;
    end else begin
      if (grant_valid) begin
        last_grant <= grant_idx;
        rd_pending <= sel_wren ? 3'b000 : grant_onehot;
      end else begin
        rd_pending <= 3'b000;
      end

      if (lock_valid) begin
        if ((bus.req & owner_mask) == 3'b000) begin
          lock_valid <= 1'b0;
        end else if (grant_valid && !sel_lock) begin
          lock_valid <= 1'b0;
        end
      end else if (grant_valid && sel_lock) begin
        lock_valid <= 1'b1;
        lock_owner <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_s_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_s_mem_arbiter
// Directed bench for s_mem_arbiter with a behavioural 256x8 synchronous
// memory (1-cycle read latency). Inputs change on the falling edge and
// outputs are sampled 1 time unit later, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_s_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_wren;
  logic [7:0] mem_q;
  logic [7:0] mem [256];

  logic       nxt_rst_n;
  logic [7:0] a0, a1, a2, d0, d1, d2;

  int tests_run;
  int tests_failed;

  s_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  s_mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .mem_q    (mem_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural s_mem: write on the rising edge, registered read data.
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One cycle: drive on the falling edge, settle, then the caller checks.
  task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l,
                               input logic [2:0] w);
    @(negedge clk);
    rst_n       = nxt_rst_n;
    bus.req     = r;
    bus.lock    = l;
    bus.wren    = w;
    bus.addr0   = a0;
    bus.addr1   = a1;
    bus.addr2   = a2;
    bus.wrdata0 = d0;
    bus.wrdata1 = d1;
    bus.wrdata2 = d2;
    #1;
  endtask

  task automatic checkBus(input string tag, input logic [2:0] exp_ack,
                          input logic [2:0] exp_rv, input logic exp_wren);
    checkOutput({tag, ".ack"}, {29'd0, bus.ack}, {29'd0, exp_ack});
    checkOutput({tag, ".rdvalid"}, {29'd0, bus.rdvalid}, {29'd0, exp_rv});
    checkOutput({tag, ".mem_wren"}, {31'd0, mem_wren}, {31'd0, exp_wren});
  endtask

  logic [2:0] rr_ack  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  logic [2:0] rr_rv   [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  logic [7:0] rr_addr [6] = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};
  logic [7:0] rr_data [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; nxt_rst_n = 1'b0;
    bus.req = '0; bus.lock = '0; bus.wren = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.wrdata0 = '0; bus.wrdata1 = '0; bus.wrdata2 = '0;
    a0 = 8'h00; a1 = 8'h00; a2 = 8'h00;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;

    // Reset with idle bus, then reset with everyone trying to write.
    applyStimulus(3'b000, 3'b000, 3'b000);
    checkBus("rst_idle0", 3'b000, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000, 3'b000);
    checkBus("rst_idle1", 3'b000, 3'b000, 1'b0);
    a0 = 8'h44; d0 = 8'hEE;
    applyStimulus(3'b111, 3'b000, 3'b111);
    checkBus("rst_req", 3'b000, 3'b000, 1'b0);
    checkOutput("rst_req.mem_addr", {24'd0, mem_addr}, 32'h0);

    // Single write then read by init.
    nxt_rst_n = 1'b1;
    a0 = 8'h05; d0 = 8'hA7;
    applyStimulus(3'b001, 3'b000, 3'b001);
    checkBus("wr_init", 3'b001, 3'b000, 1'b1);
    checkOutput("wr_init.mem_addr", {24'd0, mem_addr}, 32'h05);
    checkOutput("wr_init.mem_data", {24'd0, mem_data}, 32'hA7);
    applyStimulus(3'b001, 3'b000, 3'b000);
    checkBus("rd_init", 3'b001, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000, 3'b000);
    checkBus("rd_ret", 3'b000, 3'b001, 1'b0);
    checkOutput("rd_ret.rddata", {24'd0, bus.rddata}, 32'hA7);
    checkOutput("idle.mem_addr", {24'd0, mem_addr}, 32'h0);

    // Preload 0x10/0x20/0x30; prga writes last so init is next in line.
    a0 = 8'h10; d0 = 8'h11;
    applyStimulus(3'b001, 3'b000, 3'b001);
    checkBus("pre10", 3'b001, 3'b000, 1'b1);
    a0 = 8'h20; d0 = 8'h22;
    applyStimulus(3'b001, 3'b000, 3'b001);
    checkBus("pre20", 3'b001, 3'b000, 1'b1);
    a2 = 8'h30; d2 = 8'h33;
    applyStimulus(3'b100, 3'b000, 3'b100);
    checkBus("pre30", 3'b100, 3'b000, 1'b1);

    // Round robin with all three reading.
    a0 = 8'h10; a1 = 8'h20; a2 = 8'h30;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'b111, 3'b000, 3'b000);
      checkBus($sformatf("rr%0d", i), rr_ack[i], rr_rv[i], 1'b0);
      checkOutput($sformatf("rr%0d.mem_addr", i), {24'd0, mem_addr}, {24'd0, rr_addr[i]});
      if (i > 0)
        checkOutput($sformatf("rr%0d.rddata", i), {24'd0, bus.rddata}, {24'd0, rr_data[i]});
    end
    applyStimulus(3'b000, 3'b000, 3'b000);
    checkBus("rr_drain", 3'b000, 3'b100, 1'b0);
    checkOutput("rr_drain.rddata", {24'd0, bus.rddata}, 32'h33);

    // Swap operands: S[0x9C]=C3 (prga), S[0x03]=5A (init).
    a2 = 8'h9C; d2 = 8'hC3;
    applyStimulus(3'b100, 3'b000, 3'b100);
    checkBus("pre9c", 3'b100, 3'b000, 1'b1);
    a0 = 8'h03; d0 = 8'h5A;
    applyStimulus(3'b001, 3'b000, 3'b001);
    checkBus("pre03", 3'b001, 3'b000, 1'b1);

    // Locked swap by ksa while init and prga keep requesting reads.
    a0 = 8'h10; a2 = 8'h30;
    a1 = 8'h03;
    applyStimulus(3'b111, 3'b010, 3'b000);
    checkBus("lk1", 3'b010, 3'b000, 1'b0);
    checkOutput("lk1.mem_addr", {24'd0, mem_addr}, 32'h03);
    a1 = 8'h9C;
    applyStimulus(3'b111, 3'b010, 3'b000);
    checkBus("lk2", 3'b010, 3'b010, 1'b0);
    checkOutput("lk2.rddata", {24'd0, bus.rddata}, 32'h5A);
    a1 = 8'h03; d1 = 8'hC3;
    applyStimulus(3'b111, 3'b010, 3'b010);
    checkBus("lk3", 3'b010, 3'b010, 1'b1);
    checkOutput("lk3.rddata", {24'd0, bus.rddata}, 32'hC3);
    checkOutput("lk3.mem_data", {24'd0, mem_data}, 32'hC3);
    a1 = 8'h9C; d1 = 8'h5A;
    applyStimulus(3'b111, 3'b000, 3'b010);
    checkBus("lk4", 3'b010, 3'b000, 1'b1);
    checkOutput("lk4.mem_addr", {24'd0, mem_addr}, 32'h9C);
    // Released: prga next; init's lock bit while not granted is ignored.
    applyStimulus(3'b101, 3'b001, 3'b000);
    checkBus("lk5", 3'b100, 3'b000, 1'b0);
    checkOutput("lk5.mem_addr", {24'd0, mem_addr}, 32'h30);
    applyStimulus(3'b101, 3'b000, 3'b000);
    checkBus("lk6", 3'b001, 3'b100, 1'b0);
    checkOutput("lk6.rddata", {24'd0, bus.rddata}, 32'h33);
    a0 = 8'h03;
    applyStimulus(3'b001, 3'b000, 3'b000);
    checkBus("lk7", 3'b001, 3'b001, 1'b0);
    checkOutput("lk7.rddata", {24'd0, bus.rddata}, 32'h11);

    // Lock released by the owner dropping req.
    a1 = 8'h9C;
    applyStimulus(3'b011, 3'b010, 3'b000);
    checkBus("drop1", 3'b010, 3'b001, 1'b0);
    checkOutput("drop1.rddata", {24'd0, bus.rddata}, 32'hC3);
    applyStimulus(3'b001, 3'b000, 3'b000);
    checkBus("drop2", 3'b000, 3'b010, 1'b0);
    checkOutput("drop2.rddata", {24'd0, bus.rddata}, 32'h5A);
    applyStimulus(3'b001, 3'b000, 3'b000);
    checkBus("drop3", 3'b001, 3'b000, 1'b0);

    // Reset in the cycle after a prga read.
    a2 = 8'h30;
    applyStimulus(3'b100, 3'b000, 3'b000);
    checkBus("mr1", 3'b100, 3'b001, 1'b0);
    checkOutput("mr1.rddata", {24'd0, bus.rddata}, 32'hC3);
    nxt_rst_n = 1'b0;
    applyStimulus(3'b111, 3'b000, 3'b111);
    checkBus("mr2", 3'b000, 3'b000, 1'b0);
    nxt_rst_n = 1'b1;
    a0 = 8'h10;
    applyStimulus(3'b111, 3'b000, 3'b000);
    checkBus("mr3", 3'b001, 3'b000, 1'b0);
    applyStimulus(3'b000, 3'b000, 3'b000);
    checkBus("mr4", 3'b000, 3'b001, 1'b0);
    checkOutput("mr4.rddata", {24'd0, bus.rddata}, 32'h11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/s_mem_arbiter.md
Name: s_mem_arbiter

Overview:
- Shares the single-port 256x8 S memory (s_mem) between three requesters: init (0), ksa (1) and prga (2).
- Uses round-robin arbitration and grants at most one memory access per cycle.
- Supports a lock so that ksa or prga can perform an uninterrupted read-read-write-write swap.
- Sits between the task-level sequencer and s_mem. It replaces per-state address/data muxing in the top level.

Parameters:
- AW, 8, address width of S memory.
- DW, 8, data width of S memory.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req[2:0]  in  3  per-requester access request; bit 0 init, bit 1 ksa, bit 2 prga.
- lock[2:0]  in  3  per-requester lock request, qualified by that requester's grant.
- wren[2:0]  in  3  per-requester write enable; 0 means read.
- addr0/addr1/addr2  in  AW each  per-requester address.
- wrdata0/wrdata1/wrdata2  in  DW each  per-requester write data.
- ack[2:0]  out  3  one-hot; pulses in the cycle the access is issued to memory.
- rdvalid[2:0]  out  3  one-hot; pulses one cycle after a granted read.
- rddata  out  DW  read data broadcast to all requesters; valid only when an rdvalid bit is set.
- mem_addr  out  AW  to s_mem address.
- mem_data  out  DW  to s_mem data.
- mem_wren  out  1  to s_mem wren.
- mem_q  in  DW  from s_mem q; read latency is 1 cycle.

Behaviour:
- Reset state (rst_n=0 at posedge):
  - last_grant=2, so init has first priority.
  - lock_valid=0; rd_pending=0; rdvalid=0.
  - Combinational outputs are forced to ack=0, mem_wren=0, mem_addr=0, mem_data=0 during reset.
- Handshake:
  - A requester holds req, addr, wren and wrdata stable until it sees ack=1 at a posedge.
  - One ack equals exactly one memory access. If req stays high after ack, it is a new access.
- Arbitration is combinational, within the same cycle:
  - Candidate set is req, masked to the lock owner only when lock_valid=1.
  - Search order starts at (last_grant+1) mod 3 and wraps.
  - The first requester found gets ack; mem_addr, mem_data and mem_wren are driven from its inputs.
  - If no candidate exists, ack=0 and mem_wren=0. mem_addr is don't-care, but is driven to 0.
- Pointer update: at each posedge with a grant, last_grant takes the granted index. With no grant, last_grant holds.
- Read return:
  - A granted read (wren=0) sets rd_pending to the granted one-hot.
  - Next cycle, rdvalid=rd_pending and rddata=mem_q, passed through combinationally from s_mem.
  - Back-to-back reads are allowed, one issued per cycle. Each rdvalid follows its ack by exactly 1 cycle.
- Write: a granted write (wren=1) produces an ack only. It produces no rdvalid.
- Lock:
  - Granted with lock=1: lock_valid=1 and lock_owner=index.
  - Owner granted with lock=0: lock released after that access.
  - Owner has req=0 for any cycle: lock released at that posedge.
  - While locked, other requesters get no ack. Their requests stay pending and are not dropped.
  - After release, round-robin resumes from the owner's index. The owner is therefore lowest priority next.
- Simultaneous events: req from all three with no lock gives grant order 0,1,2,0,... when all hold req.
- A lock request from a non-granted requester is ignored.
- Reset mid-operation:
  - Pending rdvalid is suppressed and the lock is cleared.
  - Any in-flight memory write issued in the reset cycle is blocked, because mem_wren=0 while rst_n=0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=000 -> ack=000, rdvalid=000, mem_wren=0 every cycle.
- Single write/read: init writes addr 0x05 data 0xA7 -> ack[0] same cycle, mem_wren=1. Then init reads 0x05 -> ack[0]; next cycle rdvalid=001 and rddata=0xA7.
- Round-robin: req=111, all reads of addr 0x10/0x20/0x30 held for 6 cycles -> ack sequence 001,010,100,001,010,100. The rdvalid sequence is the same shifted 1 cycle, with mem_addr 0x10,0x20,0x30 repeating.
- Lock swap: ksa issues read 0x03 with lock=1, read 0x9C with lock=1, write 0x03 with lock=1, write 0x9C with lock=0, while init and prga hold req -> four consecutive ack=010. The next grant goes to prga (100), then init.
- Lock release by dropping req: ksa locks, then req[1]=0 for one cycle while req[0]=1 -> the following cycle ack=001.
- Reset mid-read: grant a read by prga, assert rst_n=0 the next cycle -> rdvalid=000 in that cycle. After reset, req=111 grants init first (ack=001).
